// File: rtl/cpc_ram_bank_ctrl.sv
// cpc_ram_bank_ctrl: banking controller for the CPC 512K RAM expansion.
// It qualifies Z80 I/O writes to the gate-array RAM config port and
// commits each write exactly once. It also decodes each memory access
// to the expansion SRAM.
// Ports: CLK, RESET (sync, active high), A15, A14, D[7:0], IOREQ_B,
// WR_B, M1_B, MREQ_B in; RAMDIS, ramcs_b, ram_adr_hi, cfg_q, cfg_wr out.
module cpc_ram_bank_ctrl #(
   parameter int BANK_BITS   = 3,
   parameter int QUAL_CYCLES = 2
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 A15,
   input  logic                 A14,
   input  logic [7:0]           D,
   input  logic                 IOREQ_B,
   input  logic                 WR_B,
   input  logic                 M1_B,
   input  logic                 MREQ_B,
   output logic                 RAMDIS,
   output logic                 ramcs_b,
   output logic [BANK_BITS+1:0] ram_adr_hi,
   output logic [BANK_BITS+2:0] cfg_q,
   output logic                 cfg_wr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      QUAL   = 2'd1,
      COMMIT = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam logic [2:0] QLAST = 3'(QUAL_CYCLES - 1);

   state_t                 state;
   logic   [2:0]           cnt;
   logic                   hit;
   logic   [2:0]           mode;
   logic   [BANK_BITS-1:0] bank;
   logic   [1:0]           page;
   logic                   ext;
   logic   [1:0]           blk;

   // M1_B high excludes interrupt acknowledge cycles
   assign hit = !IOREQ_B && !WR_B && M1_B && !A15 && D[7] && D[6];

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= IDLE;
         cnt    <= 3'd0;
         cfg_q  <= '0;
         cfg_wr <= 1'b0;
      end else begin
         cfg_wr <= 1'b0;
         unique case (state)
            IDLE: begin
               if (hit) begin
                  if (QUAL_CYCLES == 1) begin
                     state <= COMMIT;
                     cnt   <= 3'd0;
                  end else begin
                     state <= QUAL;
                     cnt   <= 3'd1;
                  end
               end
            end
            QUAL: begin
               if (!hit) begin
                  state <= IDLE;
                  cnt   <= 3'd0;
               end else if (cnt == QLAST) begin
                  state <= COMMIT;
                  cnt   <= 3'd0;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            COMMIT: begin
               cfg_q  <= {D[2+BANK_BITS:3], D[2:0]};
               cfg_wr <= 1'b1;
               state  <= HOLD;
            end
            HOLD: begin
               // one commit per bus cycle, however many wait states
               if (IOREQ_B) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mode = cfg_q[2:0];
   assign bank = cfg_q[BANK_BITS+2:3];
   assign page = {A15, A14};

   always_comb begin
      ext = 1'b0;
      blk = 2'b00;
      case (mode)
         3'd0: begin
            ext = 1'b0;
         end
         3'd1, 3'd3: begin
            // mode 3 maps page 1 to internal block 3, so not ext there
            ext = (page == 2'd3);
            blk = 2'd3;
         end
         3'd2: begin
            ext = 1'b1;
            blk = page;
         end
         default: begin
            ext = (page == 2'd1);
            blk = mode[1:0];
         end
      endcase
   end

   assign RAMDIS     = ext;
   assign ramcs_b    = !(ext && !MREQ_B);
   assign ram_adr_hi = {bank, (ext ? blk : 2'b00)};

endmodule

// File: tb/tb_cpc_ram_bank_ctrl.sv
// tb_cpc_ram_bank_ctrl: directed self-checking bench for
// cpc_ram_bank_ctrl with default parameters (3 bank bits, 2 qual cycles).
module tb_cpc_ram_bank_ctrl;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       A15, A14;
   logic [7:0] D;
   logic       IOREQ_B, WR_B, M1_B, MREQ_B;
   logic       RAMDIS, ramcs_b, cfg_wr;
   logic [4:0] ram_adr_hi;
   logic [5:0] cfg_q;

   int tests_run    = 0;
   int tests_failed = 0;
   int pulses;
   int first_edge;

   cpc_ram_bank_ctrl #(.BANK_BITS(3), .QUAL_CYCLES(2)) dut (
      .CLK(CLK), .RESET(RESET), .A15(A15), .A14(A14), .D(D),
      .IOREQ_B(IOREQ_B), .WR_B(WR_B), .M1_B(M1_B), .MREQ_B(MREQ_B),
      .RAMDIS(RAMDIS), .ramcs_b(ramcs_b), .ram_adr_hi(ram_adr_hi),
      .cfg_q(cfg_q), .cfg_wr(cfg_wr)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic bus_idle();
      IOREQ_B = 1'b1;
      WR_B    = 1'b1;
      M1_B    = 1'b1;
      MREQ_B  = 1'b1;
      A15     = 1'b0;
      A14     = 1'b0;
      D       = 8'h00;
   endtask

   // Hold an I/O cycle for 'hold' edges, then release for 'rel' edges,
   // counting cfg_wr pulses and noting the first edge one was seen.
   task automatic drive_io(input logic [7:0] d, input logic a15,
                           input logic wr_b, input logic m1_b,
                           input int hold, input int rel,
                           output int np, output int fe);
      np = 0;
      fe = 0;
      D       = d;
      A15     = a15;
      IOREQ_B = 1'b0;
      WR_B    = wr_b;
      M1_B    = m1_b;
      for (int i = 1; i <= hold + rel; i++) begin
         if (i == hold + 1) begin
            IOREQ_B = 1'b1;
            WR_B    = 1'b1;
            M1_B    = 1'b1;
            A15     = 1'b0;
         end
         tick();
         if (cfg_wr) begin
            np++;
            if (fe == 0) fe = i;
         end
      end
   endtask

   task automatic test_reset();
      bus_idle();
      RESET = 1'b1;
      tick();
      tick();
      RESET = 1'b0;
      tests_run++;
      if (cfg_q !== 6'd0 || cfg_wr !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_cfg: cfg_q=%b cfg_wr=%b want 0/0",
                  cfg_q, cfg_wr);
      end
      MREQ_B = 1'b0;
      for (int p = 0; p < 4; p++) begin
         {A15, A14} = 2'(p);
         #1;
         tests_run++;
         if (RAMDIS !== 1'b0 || ramcs_b !== 1'b1 ||
             ram_adr_hi !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_page%0d: RAMDIS=%b cs=%b adr=%b want 0 1 0",
                     p, RAMDIS, ramcs_b, ram_adr_hi);
         end
      end
      bus_idle();
   endtask

   task automatic test_mode2();
      drive_io(8'hC2, 1'b0, 1'b0, 1'b1, 3, 2, pulses, first_edge);
      tests_run++;
      if (pulses !== 1 || first_edge !== 3) begin
         tests_failed++;
         $display("FAIL mode2_pulse: pulses=%0d edge=%0d want 1 at 3",
                  pulses, first_edge);
      end
      tests_run++;
      if (cfg_q !== 6'b000010) begin
         tests_failed++;
         $display("FAIL mode2_cfg: cfg_q=%b want 000010", cfg_q);
      end
      MREQ_B = 1'b0;
      for (int p = 0; p < 4; p++) begin
         {A15, A14} = 2'(p);
         #1;
         tests_run++;
         if (ramcs_b !== 1'b0 || RAMDIS !== 1'b1 ||
             ram_adr_hi !== 5'(p)) begin
            tests_failed++;
            $display("FAIL mode2_page%0d: cs=%b RAMDIS=%b adr=%b want 0 1 %0d",
                     p, ramcs_b, RAMDIS, ram_adr_hi, p);
         end
      end
      MREQ_B = 1'b1;
      #1;
      tests_run++;
      if (ramcs_b !== 1'b1 || RAMDIS !== 1'b1) begin
         tests_failed++;
         $display("FAIL mode2_nomreq: cs=%b RAMDIS=%b want 1 1",
                  ramcs_b, RAMDIS);
      end
      bus_idle();
   endtask

   task automatic test_stretched();
      logic [4:0] exp_adr;
      drive_io(8'hEE, 1'b0, 1'b0, 1'b1, 10, 2, pulses, first_edge);
      tests_run++;
      if (pulses !== 1 || first_edge !== 3) begin
         tests_failed++;
         $display("FAIL stretch_pulse: pulses=%0d edge=%0d want 1 at 3",
                  pulses, first_edge);
      end
      tests_run++;
      if (cfg_q !== 6'b101110) begin
         tests_failed++;
         $display("FAIL stretch_cfg: cfg_q=%b want 101110", cfg_q);
      end
      MREQ_B = 1'b0;
      for (int p = 0; p < 4; p++) begin
         {A15, A14} = 2'(p);
         #1;
         exp_adr = (p == 1) ? 5'b10110 : 5'b10100;
         tests_run++;
         if (RAMDIS !== (p == 1) || ramcs_b !== (p != 1) ||
             ram_adr_hi !== exp_adr) begin
            tests_failed++;
            $display("FAIL stretch_page%0d: RAMDIS=%b cs=%b adr=%b want %b %b %b",
                     p, RAMDIS, ramcs_b, ram_adr_hi, p == 1, p != 1, exp_adr);
         end
      end
      bus_idle();
   endtask

   task automatic test_rejects();
      logic [7:0] dv [4] = '{8'hC1, 8'hC1, 8'h82, 8'hC1};
      logic       av [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic       mv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      int         hv [4] = '{1, 4, 4, 4};
      for (int k = 0; k < 4; k++) begin
         drive_io(dv[k], av[k], 1'b0, mv[k], hv[k], 5 - hv[k],
                  pulses, first_edge);
         tests_run++;
         if (pulses !== 0 || cfg_q !== 6'b101110) begin
            tests_failed++;
            $display("FAIL reject%0d: pulses=%0d cfg_q=%b want 0 101110",
                     k, pulses, cfg_q);
         end
      end
      bus_idle();
   endtask

   task automatic test_mode3_mode1();
      drive_io(8'hC3, 1'b0, 1'b0, 1'b1, 3, 2, pulses, first_edge);
      MREQ_B = 1'b0;
      {A15, A14} = 2'd1;
      #1;
      tests_run++;
      if (RAMDIS !== 1'b0 || ramcs_b !== 1'b1) begin
         tests_failed++;
         $display("FAIL mode3_page1: RAMDIS=%b cs=%b want 0 1",
                  RAMDIS, ramcs_b);
      end
      {A15, A14} = 2'd3;
      #1;
      tests_run++;
      if (RAMDIS !== 1'b1 || ramcs_b !== 1'b0 ||
          ram_adr_hi !== 5'b00011) begin
         tests_failed++;
         $display("FAIL mode3_page3: RAMDIS=%b cs=%b adr=%b want 1 0 00011",
                  RAMDIS, ramcs_b, ram_adr_hi);
      end
      bus_idle();
      drive_io(8'hF9, 1'b0, 1'b0, 1'b1, 3, 2, pulses, first_edge);
      MREQ_B = 1'b0;
      {A15, A14} = 2'd3;
      #1;
      tests_run++;
      if (cfg_q !== 6'b111001 || ramcs_b !== 1'b0 ||
          ram_adr_hi !== 5'b11111) begin
         tests_failed++;
         $display("FAIL mode1_page3: cfg=%b cs=%b adr=%b want 111001 0 11111",
                  cfg_q, ramcs_b, ram_adr_hi);
      end
      {A15, A14} = 2'd1;
      #1;
      tests_run++;
      if (RAMDIS !== 1'b0 || ram_adr_hi !== 5'b11100) begin
         tests_failed++;
         $display("FAIL mode1_page1: RAMDIS=%b adr=%b want 0 11100",
                  RAMDIS, ram_adr_hi);
      end
      bus_idle();
      drive_io(8'hFF, 1'b0, 1'b0, 1'b1, 3, 2, pulses, first_edge);
      MREQ_B = 1'b0;
      {A15, A14} = 2'd1;
      #1;
      tests_run++;
      if (ramcs_b !== 1'b0 || ram_adr_hi !== 5'b11111) begin
         tests_failed++;
         $display("FAIL mode7_page1: cs=%b adr=%b want 0 11111",
                  ramcs_b, ram_adr_hi);
      end
      bus_idle();
   endtask

   task automatic test_reset_mid();
      int np;
      np = 0;
      // reset while in QUAL
      D = 8'hC2; IOREQ_B = 1'b0; WR_B = 1'b0;
      tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      bus_idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         if (cfg_wr) np++;
      end
      tests_run++;
      if (np !== 0 || cfg_q !== 6'd0) begin
         tests_failed++;
         $display("FAIL rst_qual: pulses=%0d cfg_q=%b want 0 0", np, cfg_q);
      end
      // reset while in COMMIT: pending write dropped
      np = 0;
      D = 8'hEE; IOREQ_B = 1'b0; WR_B = 1'b0;
      tick();
      tick();
      RESET = 1'b1;
      tick();
      if (cfg_wr) np++;
      RESET = 1'b0;
      bus_idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         if (cfg_wr) np++;
      end
      tests_run++;
      if (np !== 0 || cfg_q !== 6'd0) begin
         tests_failed++;
         $display("FAIL rst_commit: pulses=%0d cfg_q=%b want 0 0", np, cfg_q);
      end
      // reset while in HOLD clears the committed config
      D = 8'hEE; IOREQ_B = 1'b0; WR_B = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      bus_idle();
      tick();
      tests_run++;
      if (cfg_q !== 6'd0 || cfg_wr !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_hold: cfg_q=%b cfg_wr=%b want 0 0", cfg_q, cfg_wr);
      end
      drive_io(8'hD5, 1'b0, 1'b0, 1'b1, 3, 2, pulses, first_edge);
      tests_run++;
      if (pulses !== 1 || first_edge !== 3 || cfg_q !== 6'b010101) begin
         tests_failed++;
         $display("FAIL rst_after: pulses=%0d edge=%0d cfg_q=%b want 1 3 010101",
                  pulses, first_edge, cfg_q);
      end
   endtask

   initial begin
      RESET = 1'b1;
      bus_idle();
      test_reset();
      test_mode2();
      test_stretched();
      test_rejects();
      test_mode3_mode1();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
